// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target at DEV_ADDR with a 16x8 register file
// mapped at REG_BASE, supporting pointer writes and repeated-start reads.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h38,
  parameter logic [7:0] REG_BASE = 8'h40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic       loc_we,
  input  logic [3:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic       wr_pulse,
  output logic [7:0] wr_reg,
  output logic [7:0] wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK,
    WDATA, WDATA_ACK, RDATA, RACK, IGNORE
  } state_t;

  state_t      state, state_nxt;
  logic [2:0]  scl_q, sda_q;
  logic        scl, sda, scl_d, sda_d;
  logic        scl_rise, scl_fall, start, stop;
  logic [3:0]  cnt, cnt_nxt;
  logic [7:0]  sh, sh_nxt;
  logic [7:0]  ptr, ptr_nxt;
  logic [7:0]  tx, tx_nxt;
  logic        rw, rw_nxt;
  logic        mack, mack_nxt;
  logic        oe_nxt, busy_nxt, wr_en;
  logic [7:0]  regs [16];
  logic [7:0]  idx, rd_byte;
  logic        hit;

  // [1] is the synchronized level, [2] its one-clk-older copy
  assign scl      = scl_q[1];
  assign scl_d    = scl_q[2];
  assign sda      = sda_q[1];
  assign sda_d    = sda_q[2];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

  assign idx     = ptr - REG_BASE;
  assign hit     = (idx[7:4] == 4'h0);
  assign rd_byte = hit ? regs[idx[3:0]] : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_in};
      sda_q <= {sda_q[1:0], sda_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    oe_nxt    = sda_oe;
    busy_nxt  = busy;
    cnt_nxt   = cnt;
    sh_nxt    = sh;
    ptr_nxt   = ptr;
    tx_nxt    = tx;
    rw_nxt    = rw;
    mack_nxt  = mack;
    wr_en     = 1'b0;
    if (start) begin
      state_nxt = ADDR;
      cnt_nxt   = 4'd0;
      busy_nxt  = 1'b0;
      oe_nxt    = 1'b0;
    end else if (stop) begin
      state_nxt = IDLE;
      busy_nxt  = 1'b0;
      oe_nxt    = 1'b0;
    end else if (scl_rise) begin
      if ((state inside {ADDR, PTR, WDATA}) && cnt < 4'd8) begin
        sh_nxt  = {sh[6:0], sda};
        cnt_nxt = cnt + 4'd1;
      end
      if (state == RACK) begin
        mack_nxt = sda;
        ptr_nxt  = ptr + 8'd1;
      end
    end else if (scl_fall) begin
      unique case (state)
        ADDR: if (cnt == 4'd8) begin
          if (sh[7:1] == DEV_ADDR) begin
            oe_nxt    = 1'b1;
            busy_nxt  = 1'b1;
            rw_nxt    = sh[0];
            state_nxt = ADDR_ACK;
          end else begin
            state_nxt = IDLE;
          end
        end
        ADDR_ACK: begin
          cnt_nxt = 4'd0;
          if (rw) begin
            tx_nxt    = rd_byte;
            oe_nxt    = ~rd_byte[7];
            state_nxt = RDATA;
          end else begin
            oe_nxt    = 1'b0;
            state_nxt = PTR;
          end
        end
        PTR: if (cnt == 4'd8) begin
          ptr_nxt   = sh;
          oe_nxt    = 1'b1;
          state_nxt = PTR_ACK;
        end
        PTR_ACK, WDATA_ACK: begin
          oe_nxt    = 1'b0;
          cnt_nxt   = 4'd0;
          state_nxt = WDATA;
        end
        WDATA: if (cnt == 4'd8) begin
          wr_en     = hit;
          ptr_nxt   = ptr + 8'd1;
          oe_nxt    = 1'b1;
          state_nxt = WDATA_ACK;
        end
        RDATA: begin
          if (cnt == 4'd7) begin
            oe_nxt    = 1'b0;
            state_nxt = RACK;
          end else begin
            oe_nxt  = ~tx[6];
            tx_nxt  = {tx[6:0], 1'b0};
            cnt_nxt = cnt + 4'd1;
          end
        end
        RACK: begin
          if (!mack) begin
            tx_nxt    = rd_byte;
            oe_nxt    = ~rd_byte[7];
            cnt_nxt   = 4'd0;
            state_nxt = RDATA;
          end else begin
            state_nxt = IGNORE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      cnt      <= 4'd0;
      sh       <= 8'h00;
      ptr      <= 8'h00;
      tx       <= 8'h00;
      rw       <= 1'b0;
      mack     <= 1'b0;
      wr_pulse <= 1'b0;
      wr_reg   <= 8'h00;
      wr_data  <= 8'h00;
      for (int i = 0; i < 16; i++) regs[i] <= 8'h00;
    end else begin
      sda_oe   <= oe_nxt;
      busy     <= busy_nxt;
      cnt      <= cnt_nxt;
      sh       <= sh_nxt;
      ptr      <= ptr_nxt;
      tx       <= tx_nxt;
      rw       <= rw_nxt;
      mack     <= mack_nxt;
      wr_pulse <= wr_en;
      if (wr_en) begin
        regs[idx[3:0]] <= sh;
        wr_reg         <= ptr;
        wr_data        <= sh;
      end
      // later assignment: local port wins a same-cycle collision
      if (loc_we) regs[loc_addr] <= loc_wdata;
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: bit-banged I2C master against a register-map
// model of the target, with directed and random transactions.
module tb_i2c_target_regs;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       loc_we = 1'b0;
  logic [3:0] loc_addr = 4'h0;
  logic [7:0] loc_wdata = 8'h00;
  logic       sda_line, sda_oe, wr_pulse, busy;
  logic [7:0] wr_reg, wr_data;

  assign sda_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_in    (m_scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .loc_we    (loc_we),
    .loc_addr  (loc_addr),
    .loc_wdata (loc_wdata),
    .wr_pulse  (wr_pulse),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  int          oe_cnt = 0;
  int          pn = 0;
  int          pr = 0;
  logic [15:0] plog [0:1023];

  always @(negedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (wr_pulse) begin
      plog[pn] <= {wr_reg, wr_data};
      pn <= pn + 1;
    end
  end

  logic [7:0]  mem [0:255];
  logic [7:0]  mptr;
  logic [15:0] eq [$];
  logic [7:0]  wq [$];

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(logic [7:0] p);
    return p >= 8'h40 && p <= 8'h4F;
  endfunction

  function automatic logic [7:0] mread(logic [7:0] p);
    return in_rng(p) ? mem[p] : 8'h00;
  endfunction

  task automatic mreset;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mptr = 8'h00;
  endtask

  task automatic wt(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bstart;
    m_sda = 1'b1; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b0;
  endtask

  task automatic bstop;
    m_sda = 1'b0; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_sda = 1'b1; wt(Q);
  endtask

  task automatic wbit(logic b);
    m_sda = b; wt(Q);
    m_scl = 1'b1; wt(Q);
    m_scl = 1'b0;
  endtask

  task automatic wbyte(logic [7:0] b, bit coll, output bit ack);
    for (int i = 7; i >= 0; i--) wbit(b[i]);
    m_sda = 1'b1;
    if (coll) begin
      wt(2);
      loc_we = 1'b1;
      wt(1);
      loc_we = 1'b0;
      chk("coll_pulse", wr_pulse, 1);
      wt(Q - 3);
    end else begin
      wt(Q);
    end
    m_scl = 1'b1; wt(Q / 2);
    ack = ~sda_line;
    wt(Q - Q / 2);
    m_scl = 1'b0;
  endtask

  task automatic rbyte(bit nack, output logic [7:0] b);
    m_sda = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wt(Q);
      m_scl = 1'b1; wt(Q / 2);
      b[i] = sda_line;
      wt(Q - Q / 2);
      m_scl = 1'b0;
    end
    m_sda = nack; wt(Q);
    m_scl = 1'b1; wt(Q / 2);
    if (nack) chk("nack_line", sda_line, 1);
    wt(Q - Q / 2);
    m_scl = 1'b0;
  endtask

  task automatic lwrite(logic [3:0] a, logic [7:0] d);
    @(negedge clk);
    loc_addr = a; loc_wdata = d; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
    mem[8'h40 + {4'h0, a}] = d;
  endtask

  task automatic chk_pulses;
    int got_n, m;
    got_n = pn - pr;
    chk("pulse_cnt", got_n, eq.size());
    m = (got_n < eq.size()) ? got_n : eq.size();
    for (int i = 0; i < m; i++) chk("pulse_val", plog[pr + i], eq[i]);
    pr = pn;
    eq.delete();
  endtask

  task automatic xwrite(logic [6:0] da, logic [7:0] rg);
    bit ack, h;
    int oe0;
    h = (da == 7'h38);
    oe0 = oe_cnt;
    bstart;
    wbyte({da, 1'b0}, 1'b0, ack);
    chk("addr_ack", ack, h);
    chk("busy_on", busy, h);
    wbyte(rg, 1'b0, ack);
    if (h) begin
      chk("ptr_ack", ack, 1);
      mptr = rg;
    end
    foreach (wq[i]) begin
      wbyte(wq[i], 1'b0, ack);
      if (h) begin
        chk("data_ack", ack, 1);
        if (in_rng(mptr)) begin
          mem[mptr] = wq[i];
          eq.push_back({mptr, wq[i]});
        end
        mptr = mptr + 8'd1;
      end
    end
    bstop;
    chk("busy_off", busy, 0);
    if (!h) chk("miss_oe", oe_cnt - oe0, 0);
    chk_pulses;
  endtask

  task automatic xread(bit rs, logic [7:0] rg, int n);
    bit ack;
    logic [7:0] b;
    int oe0;
    bstart;
    if (rs) begin
      wbyte(8'h70, 1'b0, ack);
      chk("rs_addr_ack", ack, 1);
      wbyte(rg, 1'b0, ack);
      chk("rs_ptr_ack", ack, 1);
      mptr = rg;
      bstart;
    end
    wbyte(8'h71, 1'b0, ack);
    chk("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      rbyte(i == n - 1, b);
      chk("rd_data", b, mread(mptr));
      mptr = mptr + 8'd1;
    end
    oe0 = oe_cnt;
    bstop;
    chk("rd_tail_oe", oe_cnt - oe0, 0);
    chk("rd_busy_off", busy, 0);
  endtask

  initial begin
    bit ack;
    int kind, len;
    logic [7:0] rg;
    mreset;
    wt(3);
    chk("rst_oe", sda_oe, 0);
    chk("rst_pulse", wr_pulse, 0);
    chk("rst_wreg", wr_reg, 0);
    chk("rst_wdata", wr_data, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    wt(5);

    xread(1'b1, 8'h40, 2);

    wq = '{8'hC6, 8'h02};
    xwrite(7'h38, 8'h41);
    xread(1'b1, 8'h41, 2);

    lwrite(4'h4, 8'h34);
    lwrite(4'h5, 8'h12);
    lwrite(4'h6, 8'h5A);
    xread(1'b1, 8'h44, 2);
    chk("ptr_after_rd", mptr, 8'h46);
    xread(1'b0, 8'h00, 1);

    wq = '{8'hFF};
    xwrite(7'h39, 8'h40);
    xread(1'b1, 8'h40, 1);

    wq = '{8'hAA, 8'hBB};
    xwrite(7'h38, 8'h3F);
    xread(1'b1, 8'h3F, 2);
    xread(1'b1, 8'h50, 1);
    wq = '{8'h11, 8'h22};
    xwrite(7'h38, 8'h4F);
    xread(1'b1, 8'h4E, 3);

    lwrite(4'h8, 8'h3C);
    bstart;
    wbyte(8'h70, 1'b0, ack);
    wbyte(8'h48, 1'b0, ack);
    mptr = 8'h48;
    for (int i = 0; i < 4; i++) wbit(1'b1);
    bstop;
    chk_pulses;
    wq = '{8'h77};
    xwrite(7'h38, 8'h49);
    xread(1'b1, 8'h48, 2);

    bstart;
    wbyte(8'h70, 1'b0, ack);
    wbyte(8'h43, 1'b0, ack);
    loc_addr = 4'h3;
    loc_wdata = 8'h99;
    wbyte(8'h5C, 1'b1, ack);
    chk("coll_ack", ack, 1);
    bstop;
    mem[8'h43] = 8'h99;
    eq.push_back({8'h43, 8'h5C});
    chk_pulses;
    xread(1'b1, 8'h43, 1);

    for (int t = 0; t < 14; t++) begin
      kind = $urandom_range(0, 3);
      rg = 8'h3C + 8'($urandom_range(0, 23));
      len = $urandom_range(1, 3);
      case (kind)
        0: begin
          wq.delete();
          for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
          xwrite(($urandom_range(0, 4) == 0) ? 7'h1C : 7'h38, rg);
        end
        1: xread(1'b1, rg, len);
        2: xread(1'b0, 8'h00, len);
        default: lwrite(4'($urandom), 8'($urandom));
      endcase
    end

    bstart;
    for (int i = 7; i >= 0; i--) wbit(i == 0 ? 1'b0 : ((8'h70 >> i) & 8'h01) != 0);
    m_sda = 1'b1;
    wt(Q / 2);
    chk("pre_rst_oe", sda_oe, 1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_oe", sda_oe, 0);
    chk("async_rst_busy", busy, 0);
    m_scl = 1'b1;
    wt(Q);
    rst_n = 1'b1;
    mreset;
    wt(Q);
    chk_pulses;
    xread(1'b1, 8'h41, 2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave) that answers at a 7-bit device address and exposes a 16 x 8-bit register file mapped at register addresses 0x40..0x4F.
- Decodes the standard pointer-write and repeated-start-read sequences that our I2C master drivers issue: START, addr+W, reg, data..., STOP, and START, addr+W, reg, Sr, addr+R, data(ACK)...data(NACK), STOP.
- Used as a bus-functional sensor stand-in (e.g. RPR0521RS map) on-board and in benches. The fabric side loads measurement values through a local write port and observes I2C writes.

Parameters:
DEV_ADDR  7'h38  7-bit target address
REG_BASE  8'h40  register address of file entry 0; entries occupy REG_BASE..REG_BASE+15

Ports:
clk        in   1  system clock (>= 20x SCL rate)
rst_n      in   1  asynchronous reset, active-low
scl_in     in   1  SCL pin level (asynchronous)
sda_in     in   1  SDA pin level (asynchronous)
sda_oe     out  1  1 = pull SDA low (open-drain); pad drives 0 when set, Z otherwise
loc_we     in   1  local write strobe
loc_addr   in   4  local write index
loc_wdata  in   8  local write data
wr_pulse   out  1  one-clk pulse per in-range I2C data byte written
wr_reg     out  8  register address of that write
wr_data    out  8  data of that write
busy       out  1  1 while addressed (between matching address ACK and STOP/START)

Behaviour:
- Reset: sda_oe=0, wr_pulse=0, wr_reg=0, wr_data=0, busy=0, pointer=0x00, all file entries 0x00, state IDLE.
- Input sync: 2-FF synchronizer on each of scl_in and sda_in, plus a delayed copy for edge detection. Events are detected 3 clk after a pin change.
- START: SDA falls while SCL is high. Accepted in any state, including repeated START. Goes to ADDR, clears bit count, clears busy.
- STOP: SDA rises while SCL is high. Goes to IDLE from any state, releases SDA (sda_oe=0), clears busy.
- Data bits are sampled on the SCL rising event, MSB first. sda_oe changes only on the SCL falling event.
- States:
  - IDLE: ignore everything except START.
  - ADDR: shift 8 bits. On the 8th falling event:
    - if addr[7:1]==DEV_ADDR, assert sda_oe and go to ADDR_ACK (busy=1);
    - otherwise stay released and go to IDLE.
  - ADDR_ACK: on the next falling event, release SDA.
    - If R/W=0, go to PTR.
    - If R/W=1, load the byte at the pointer, drive its MSB (sda_oe = ~bit7), and go to RDATA.
  - PTR: shift 8 bits into the pointer. ACK on the 8th falling event, go to PTR_ACK.
  - PTR_ACK: release SDA on the falling event, go to WDATA.
  - WDATA: shift 8 bits. ACK on the 8th falling event (ACK is given even when the pointer is out of range).
    - If the pointer is in range, write the file entry and pulse wr_pulse 1 clk with wr_reg=pointer, wr_data=byte.
    - Pointer increments, 8-bit wrap (0xFF -> 0x00).
    - Go to WDATA_ACK; release SDA on the falling event, go to WDATA.
  - RDATA: bits 6..0 are driven on successive falling events. On the falling event after bit 0, release SDA and go to RACK.
  - RACK: sample the master's bit on the rising event; the pointer increments.
    - ACK (0): on the falling event, load the next byte and drive its MSB, go to RDATA.
    - NACK (1): go to IGNORE, SDA released until STOP/START.
- Out-of-range pointer (outside REG_BASE..REG_BASE+15): reads return 0x00; writes are ACKed and discarded, with no wr_pulse.
- Read data is captured when the byte is loaded. A local write during the shift does not alter the byte in flight.
- Simultaneous local and I2C write to the same entry: the local write wins; wr_pulse still fires.
- Reset mid-transfer releases SDA immediately (asynchronous).
- SCL glitch or START occurring mid-byte: the START rule has priority and the partial byte is discarded.

Test Plan:
- Write transaction:
  - Stimulus: START, 0x70, 0x41, 0xC6, 0x02, STOP.
  - Required: ACK on all four bytes; wr_pulse twice with (0x41,0xC6) then (0x42,0x02); entries 1 and 2 hold 0xC6 and 0x02; busy low after STOP.
- Repeated-start read:
  - Stimulus: preload entries 4 and 5 with 0x34 and 0x12 via loc_we, then START, 0x70, 0x44, Sr, 0x71, read with ACK, read with NACK, STOP.
  - Required: bytes 0x34 then 0x12; pointer ends at 0x46; no ACK driven by the target after 0x71's data phase.
- Address mismatch:
  - Stimulus: START, 0x72, 0x40, 0xFF, STOP.
  - Required: sda_oe stays 0 throughout; no wr_pulse; the file is unchanged.
- Out of range:
  - Stimulus: write to 0x3F then 0x40 in one burst (0x3F, 0xAA, 0xBB); then read from 0x50.
  - Required: 0xAA is ACKed but discarded; entry 0 becomes 0xBB; the read of 0x50 returns 0x00.
- Abort:
  - Stimulus: STOP after 4 bits of a data byte, then START with a 0x70 write.
  - Required: no write occurs; the new transaction is ACKed normally.
  - Stimulus: assert rst_n low while the target drives an ACK.
  - Required: sda_oe drops to 0 with no clock edge.
- Collision:
  - Stimulus: loc_we on entry 3 in the same clk as the I2C write to 0x43.
  - Required: the entry holds loc_wdata; wr_pulse is asserted.
